// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline-control types and constants.
package riscv_pipe_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    // Registered data-memory command held stable while a request is outstanding.
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dmem_cmd_t;

    localparam logic [4:0] REG_X0              = 5'd0;
    localparam int         DEFAULT_MEM_TIMEOUT = 16;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Data-memory request/ack bus between the pipeline controller and memory.
interface pipe_ctrl_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use compare between the instruction in ID and a load in EX.
module load_use_detect
    import riscv_pipe_pkg::*;
(
    input  logic [4:0] rs1_id,
    input  logic [4:0] rs2_id,
    input  logic       uses_rs1_id,
    input  logic       uses_rs2_id,
    input  logic [4:0] rd_ex,
    input  logic       read_mem_ex,
    output logic       load_use
);

    // x0 never carries a real dependency, so a load targeting it is harmless.
    always_comb begin
        load_use = read_mem_ex && (rd_ex != REG_X0) &&
                   ((uses_rs1_id && (rs1_id == rd_ex)) ||
                    (uses_rs2_id && (rs2_id == rd_ex)));
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush controller: sequences multi-cycle data-memory accesses
// for the EX/MEM instruction, inserts load-use bubbles and applies branch flushes.
module pipe_ctrl
    import riscv_pipe_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_MEM_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        rs1_id,
    input  logic [4:0]        rs2_id,
    input  logic              uses_rs1_id,
    input  logic              uses_rs2_id,
    input  logic [4:0]        rd_ex,
    input  logic              read_mem_ex,
    input  logic              branch_taken_ex,
    input  logic              read_mem_mem,
    input  logic              write_mem_mem,
    input  logic [31:0]       addr_mem,
    input  logic [31:0]       wdata_mem,
    pipe_ctrl_if.master       dmem,
    output logic              pc_stall,
    output logic              if_id_stall,
    output logic              id_ex_stall,
    output logic              ex_mem_stall,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              mem_wb_bubble,
    output logic [31:0]       load_data,
    output logic              load_valid,
    output logic              bus_err
);

    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    mem_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt;
    dmem_cmd_t        cmd;
    logic             req_q;
    logic             mem_op;
    logic             mem_stall;
    logic             load_use;
    logic             ack_busy;
    logic             timeout_hit;

    assign mem_op      = read_mem_mem | write_mem_mem;
    // Acks outside BUSY (e.g. a late ack after reset) are ignored.
    assign ack_busy    = (state == BUSY) && dmem.dmem_ack;
    assign timeout_hit = (state == BUSY) && !dmem.dmem_ack && (cnt == CNT_LAST);

    load_use_detect u_load_use (
        .rs1_id      (rs1_id),
        .rs2_id      (rs2_id),
        .uses_rs1_id (uses_rs1_id),
        .uses_rs2_id (uses_rs2_id),
        .rd_ex       (rd_ex),
        .read_mem_ex (read_mem_ex),
        .load_use    (load_use)
    );

    // Access state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state: one request per EX/MEM instruction, DONE lets it advance.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (mem_op) state_nxt = BUSY;
            BUSY:    if (ack_busy || timeout_hit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Wait counter; stops at TIMEOUT-1 so it never wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                         cnt <= '0;
        else if (state == IDLE && mem_op)                 cnt <= '0;
        else if (state == BUSY && !ack_busy && !timeout_hit) cnt <= cnt + 1'b1;
    end

    // Bus command, request and load result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd        <= '0;
            req_q      <= 1'b0;
            load_data  <= '0;
            load_valid <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_op) begin
                        cmd   <= '{we: write_mem_mem, addr: addr_mem, wdata: wdata_mem};
                        req_q <= 1'b1;
                    end
                end
                BUSY: begin
                    if (ack_busy) begin
                        req_q      <= 1'b0;
                        load_data  <= cmd.we ? 32'd0 : dmem.dmem_rdata;
                        load_valid <= 1'b1;
                    end else if (timeout_hit) begin
                        req_q      <= 1'b0;
                        load_data  <= 32'd0;
                        load_valid <= 1'b1;
                        bus_err    <= 1'b1;
                    end
                end
                DONE: begin
                    load_valid <= 1'b0;
                    bus_err    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = cmd.we;
    assign dmem.dmem_addr  = cmd.addr;
    assign dmem.dmem_wdata = cmd.wdata;

    // Priority: memory stall freezes everything, then branch flush, then load-use bubble.
    always_comb begin
        mem_stall     = ((state == IDLE) && mem_op) || (state == BUSY);
        pc_stall      = mem_stall || (load_use && !branch_taken_ex);
        if_id_stall   = pc_stall;
        id_ex_stall   = mem_stall;
        ex_mem_stall  = mem_stall;
        mem_wb_bubble = mem_stall;
        if_id_flush   = !mem_stall && branch_taken_ex;
        id_ex_flush   = !mem_stall && (branch_taken_ex || load_use);
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl.
module tb_pipe_ctrl;
    localparam int TIMEOUT = 16;

    logic        clk;
    logic        rst;
    logic [4:0]  rs1_id, rs2_id, rd_ex;
    logic        uses_rs1_id, uses_rs2_id, read_mem_ex, branch_taken_ex;
    logic        read_mem_mem, write_mem_mem;
    logic [31:0] addr_mem, wdata_mem;
    logic        pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
    logic        if_id_flush, id_ex_flush, mem_wb_bubble;
    logic [31:0] load_data;
    logic        load_valid, bus_err;

    pipe_ctrl_if dif();

    pipe_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .rs1_id(rs1_id), .rs2_id(rs2_id),
        .uses_rs1_id(uses_rs1_id), .uses_rs2_id(uses_rs2_id),
        .rd_ex(rd_ex), .read_mem_ex(read_mem_ex), .branch_taken_ex(branch_taken_ex),
        .read_mem_mem(read_mem_mem), .write_mem_mem(write_mem_mem),
        .addr_mem(addr_mem), .wdata_mem(wdata_mem),
        .dmem(dif),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall),
        .id_ex_stall(id_ex_stall), .ex_mem_stall(ex_mem_stall),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .mem_wb_bubble(mem_wb_bubble),
        .load_data(load_data), .load_valid(load_valid), .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [4:0] rs1, rs2, rd;
        logic       u1, u2, ld, br;
        logic       exp_stall, exp_ifid_fl, exp_idex_fl;
    } vec_t;

    vec_t vecs[9];

    // Runs one memory instruction; wait_n<0 means memory never acks.
    task automatic mem_access(input bit wr, input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] rd, input int wait_n, input string tag);
        int   stall_cnt = 0;
        int   req_cnt   = 0;
        int   cyc       = 0;
        bit   stable    = 1'b1;
        bit   done      = 1'b0;
        logic [31:0] ld = '0;
        logic err       = 1'b0;
        logic dstall    = 1'b0;
        bit   is_to     = (wait_n < 0);
        read_mem_mem  = !wr;
        write_mem_mem = wr;
        addr_mem      = a;
        wdata_mem     = d;
        while (!done && cyc < 60) begin
            dif.dmem_ack   = dif.dmem_req && (req_cnt == wait_n);
            dif.dmem_rdata = dif.dmem_ack ? rd : 32'h0BAD0BAD;
            #1;
            cyc++;
            if (ex_mem_stall) stall_cnt++;
            if (dif.dmem_req) begin
                req_cnt++;
                if (dif.dmem_addr !== a || dif.dmem_we !== wr || dif.dmem_wdata !== d) stable = 1'b0;
            end
            if (load_valid) begin
                done   = 1'b1;
                ld     = load_data;
                err    = bus_err;
                dstall = ex_mem_stall | pc_stall;
            end
            @(posedge clk); #1;
        end
        dif.dmem_ack  = 1'b0;
        read_mem_mem  = 1'b0;
        write_mem_mem = 1'b0;
        #1;
        chk({tag, " done_seen"}, 32'(done), 32'd1);
        chk({tag, " cycles"}, cyc, is_to ? TIMEOUT + 2 : 3 + wait_n);
        chk({tag, " stall_cycles"}, stall_cnt, is_to ? TIMEOUT + 1 : 2 + wait_n);
        chk({tag, " req_cycles"}, req_cnt, is_to ? TIMEOUT : wait_n + 1);
        chk({tag, " bus_stable"}, 32'(stable), 32'd1);
        chk({tag, " load_data"}, ld, (wr || is_to) ? 32'd0 : rd);
        chk({tag, " bus_err"}, 32'(err), 32'(is_to));
        chk({tag, " done_unstalled"}, 32'(dstall), 32'd0);
        chk({tag, " valid_after"}, 32'(load_valid), 32'd0);
        chk({tag, " err_after"}, 32'(bus_err), 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        rs1_id = '0; rs2_id = '0; rd_ex = '0;
        uses_rs1_id = 0; uses_rs2_id = 0; read_mem_ex = 0; branch_taken_ex = 0;
        read_mem_mem = 0; write_mem_mem = 0; addr_mem = '0; wdata_mem = '0;
        dif.dmem_ack = 0; dif.dmem_rdata = '0;

        // rs1 rs2 rd u1 u2 ld br | stall ifid_fl idex_fl
        vecs[0] = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0};
        vecs[1] = '{5'd0, 5'd5, 5'd5, 0, 1, 1, 0, 1, 0, 1};
        vecs[2] = '{5'd0, 5'd0, 5'd0, 1, 1, 1, 0, 0, 0, 0};
        vecs[3] = '{5'd7, 5'd1, 5'd7, 1, 0, 1, 0, 1, 0, 1};
        vecs[4] = '{5'd7, 5'd1, 5'd7, 0, 1, 1, 0, 0, 0, 0};
        vecs[5] = '{5'd5, 5'd5, 5'd5, 1, 1, 0, 0, 0, 0, 0};
        vecs[6] = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 1, 1};
        vecs[7] = '{5'd0, 5'd9, 5'd9, 0, 1, 1, 1, 0, 1, 1};
        vecs[8] = '{5'd3, 5'd3, 5'd4, 1, 1, 1, 0, 0, 0, 0};

        // Reset state
        #3;
        chk("rst req", 32'(dif.dmem_req), 0);
        chk("rst we", 32'(dif.dmem_we), 0);
        chk("rst addr", dif.dmem_addr, 0);
        chk("rst wdata", dif.dmem_wdata, 0);
        chk("rst load_data", load_data, 0);
        chk("rst load_valid", 32'(load_valid), 0);
        chk("rst bus_err", 32'(bus_err), 0);
        chk("rst stalls", 32'({pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                              if_id_flush, id_ex_flush, mem_wb_bubble}), 0);
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("idle stalls", 32'({pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                               if_id_flush, id_ex_flush, mem_wb_bubble}), 0);

        // Combinational hazard/branch table in IDLE with no memory op
        for (int i = 0; i < 9; i++) begin
            rs1_id = vecs[i].rs1; rs2_id = vecs[i].rs2; rd_ex = vecs[i].rd;
            uses_rs1_id = vecs[i].u1; uses_rs2_id = vecs[i].u2;
            read_mem_ex = vecs[i].ld; branch_taken_ex = vecs[i].br;
            #1;
            chk($sformatf("vec%0d pc_stall", i), 32'(pc_stall), 32'(vecs[i].exp_stall));
            chk($sformatf("vec%0d if_id_stall", i), 32'(if_id_stall), 32'(vecs[i].exp_stall));
            chk($sformatf("vec%0d if_id_flush", i), 32'(if_id_flush), 32'(vecs[i].exp_ifid_fl));
            chk($sformatf("vec%0d id_ex_flush", i), 32'(id_ex_flush), 32'(vecs[i].exp_idex_fl));
            chk($sformatf("vec%0d id_ex_stall", i), 32'(id_ex_stall), 0);
        end
        rs1_id = '0; rs2_id = '0; rd_ex = '0;
        uses_rs1_id = 0; uses_rs2_id = 0; read_mem_ex = 0; branch_taken_ex = 0;
        @(posedge clk); #1;

        // Memory accesses; the last three run back to back
        mem_access(1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, "load0");
        mem_access(1'b1, 32'h200, 32'h12345678, 32'hCAFEF00D, 3, "store3");
        mem_access(1'b0, 32'h104, 32'h0, 32'hA5A55A5A, 1, "load1");
        mem_access(1'b0, 32'h400, 32'h0, 32'h11111111, -1, "timeout");

        // Branch held in EX during a memory stall takes effect only in DONE
        @(posedge clk); #1;
        branch_taken_ex = 1'b1;
        read_mem_mem = 1'b1; addr_mem = 32'h300;
        #1;
        chk("br idle flush", 32'({if_id_flush, id_ex_flush}), 0);
        chk("br idle pc_stall", 32'(pc_stall), 1);
        @(posedge clk); #1;
        chk("br busy flush", 32'({if_id_flush, id_ex_flush}), 0);
        @(posedge clk); #1;
        dif.dmem_ack = 1'b1; dif.dmem_rdata = 32'h55;
        #1;
        chk("br busy2 flush", 32'({if_id_flush, id_ex_flush}), 0);
        @(posedge clk); #1;
        dif.dmem_ack = 1'b0;
        chk("br done flush", 32'({if_id_flush, id_ex_flush}), 32'b11);
        chk("br done stall", 32'({pc_stall, ex_mem_stall}), 0);
        chk("br done valid", 32'(load_valid), 1);
        chk("br done data", load_data, 32'h55);
        read_mem_mem = 1'b0; branch_taken_ex = 1'b0;
        @(posedge clk); #1;

        // Async reset mid-BUSY, then a late ack must be ignored
        read_mem_mem = 1'b1; addr_mem = 32'h500;
        @(posedge clk); #1;
        chk("rb busy req", 32'(dif.dmem_req), 1);
        #2;
        rst = 1'b0;
        #1;
        chk("rb req async", 32'(dif.dmem_req), 0);
        chk("rb addr async", dif.dmem_addr, 0);
        read_mem_mem = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        dif.dmem_ack = 1'b1; dif.dmem_rdata = 32'h77;
        @(posedge clk); #1;
        chk("rb late valid", 32'(load_valid), 0);
        chk("rb late data", load_data, 0);
        dif.dmem_ack = 1'b0;
        @(posedge clk); #1;
        chk("rb late valid2", 32'(load_valid), 0);
        chk("rb idle stall", 32'(ex_mem_stall), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
